bp_cce_hybrid_pending_w_arb: RTL and testbench
==============================================

// Module: bp_cce_hybrid_pending_w_arb
// PURPOSE
//  Shares the single pending-bit write port of the CCE pending stage among num_req_p requesters.
//  Requester examples: memory-response decrement, coherence-engine clear, and the uncached path.
//  Round-robin arbitration feeds a one-entry registered output stage.
//  The downstream port may refuse a write in any cycle; the stage holds the write until accepted.
// PARAMETERS
//  bp_params_p     e_bp_default_cfg  proc config; supplies paddr_width_p
//  num_req_p       3                 number of requesters, >=2
//  starve_limit_p  16                wait cycles before forced priority (only with macro)
// PORTS
//  clk_i                 in   1                        clock, rising edge
//  reset_i               in   1                        async, active-high reset
//  req_v_i               in   num_req_p                per-requester write request valid
//  req_yumi_o            out  num_req_p                request consumed; one-hot or zero
//  req_addr_i            in   num_req_p*paddr_width_p  packed write addresses
//  req_bypass_hash_i     in   num_req_p                skip way-group hash
//  req_op_i              in   num_req_p*2              bp_cce_pending_op_e per requester
//  pending_w_v_o         out  1                        write valid to pending stage
//  pending_w_yumi_i      in   1                        pending stage accepted write
//  pending_w_addr_o      out  paddr_width_p            write address
//  pending_w_addr_bypass_hash_o  out  1                hash bypass
//  pending_up_o          out  1                        increment
//  pending_down_o        out  1                        decrement
//  pending_clear_o       out  1                        clear
//  busy_o                out  1                        output register occupied
// BEHAVIOUR
//  - Reset (async, reset_i=1):
//    - Output register empty; pending_w_v_o=0; up/down/clear/addr/bypass outputs=0.
//    - req_yumi_o=0 while reset_i=1; RR pointer=0, so requester 0 has highest priority.
//    - Reset mid-transfer drops the held write silently; requesters must re-present.
//  - Capture enable cap = ~busy_r | pending_w_yumi_i (flow-through on same-cycle drain).
//  - Arbitration:
//    - Grant only when cap=1 and |req_v_i.
//    - Winner = first valid index at or after rr_ptr, wrapping num_req_p-1 -> 0.
//  - On grant:
//    - req_yumi_o[winner]=1 in the same cycle; the register loads addr/bypass/op next edge.
//    - rr_ptr <= winner+1 mod num_req_p; the pointer is unchanged when nothing is granted.
//  - Latency: grant to pending_w_v_o=1 is 1 cycle. Sustained throughput is 1 write/cycle
//    when pending_w_yumi_i=1 every cycle.
//  - Hold rule: while pending_w_v_o=1 and pending_w_yumi_i=0, all outputs are stable and req_yumi_o=0.
//  - Empty drain: pending_w_yumi_i=1 with no new grant empties the register next edge.
//    pending_w_yumi_i with pending_w_v_o=0 is illegal (assert).
//  - Op decode, one-hot onto up/down/clear:
//    - e_pend_up -> up=1; e_pend_down -> down=1; e_pend_clear -> clear=1.
//    - The fourth encoding is illegal: assert, and decode as no-op.
//  - Requesters must hold valid and payload stable until yumi; yumi is combinational from req_v_i.
//  - busy_o = register valid = pending_w_v_o.
// CONFIGURATION
//  Macro BP_CCE_PENDING_W_ARB_STARVE_EN.
//  - Defined:
//    - Per-requester wait counter, saturating at starve_limit_p, width $clog2(starve_limit_p+1).
//    - The counter increments each cycle req_v_i[i]=1 without a grant; it clears on grant or when
//      req_v_i[i]=0.
//    - A requester whose counter equals starve_limit_p is starved. If any are starved, the winner
//      is the lowest-index starved requester, overriding RR; rr_ptr still updates to winner+1.
//  - Undefined: pure round-robin; no counters are instantiated.
// STRUCTURE
//  - bp_me_pkg: typedef enum logic [1:0] bp_cce_pending_op_e
//    {e_pend_up=2'b00, e_pend_down=2'b01, e_pend_clear=2'b10}.
//  - bp_me_pkg: packed struct bp_cce_pending_w_s {addr, bypass_hash, op}, used for req
//    packing and the output register.
//  - Sub-module bp_cce_hybrid_pending_rr_pick: combinational rotate/priority-encode of req_v
//    and rr_ptr; outputs a one-hot grant and the winner index. The starvation override wraps
//    this sub-module.
// TESTING
//  1. Single requester:
//     - Drive req_v_i=3'b010, addr=0x8000_0040, op=up, pending_w_yumi_i=1.
//     - Expect req_yumi_o=3'b010 at cycle 0; at cycle 1, pending_w_v_o=1, addr=0x8000_0040, up=1.
//  2. Round-robin fairness:
//     - Hold req_v_i=3'b111 for 6 cycles with yumi tied high.
//     - Expect grant order 0,1,2,0,1,2 and 1 write/cycle.
//  3. Backpressure:
//     - Use the scenario-1 write; hold pending_w_yumi_i=0 for 4 cycles.
//     - Expect outputs stable and req_yumi_o=0 throughout.
//     - On the yumi cycle, the next grant fires the same cycle (flow-through).
//  4. Op decode:
//     - Send down then clear on 0x1000 from different requesters.
//     - Expect down=1 then clear=1, each one-hot. op=2'b11 fires the assertion.
//  5. Async reset:
//     - Pulse reset_i mid-cycle while pending_w_v_o=1.
//     - Expect pending_w_v_o=0 immediately, before the next edge.
//     - Afterwards, req_v_i=3'b101 grants requester 0 first.
//  6. Starvation (macro defined, starve_limit_p=4):
//     - Requester 2 valid while 0 and 1 refill with yumi stalled.
//     - Expect requester 2 granted once its counter reaches 4, ahead of the RR choice.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types for the CCE pending-bit write path: processor config, pending ops,
// and the packed write record used on requester inputs and the output register.
package bp_me_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int unsigned bp_paddr_width_gp = 40;

  function automatic int unsigned bp_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return bp_paddr_width_gp;
      default:          return bp_paddr_width_gp;
    endcase
  endfunction

  typedef enum logic [1:0] {
    e_pend_up    = 2'b00,
    e_pend_down  = 2'b01,
    e_pend_clear = 2'b10
  } bp_cce_pending_op_e;

  typedef struct packed {
    logic [bp_paddr_width_gp-1:0] addr;
    logic                         bypass_hash;
    bp_cce_pending_op_e           op;
  } bp_cce_pending_w_s;

endpackage

// File: rtl/bp_cce_hybrid_pending_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr_i,
// wrapping from num_req_p-1 back to 0. Returns a one-hot grant and its index.
module bp_cce_hybrid_pending_rr_pick
  #(parameter int unsigned num_req_p = 3
   ,localparam int unsigned idx_w = $clog2(num_req_p))
  (input  logic [num_req_p-1:0] req_v_i
  ,input  logic [idx_w-1:0]     rr_ptr_i
  ,output logic [num_req_p-1:0] grant_o
  ,output logic [idx_w-1:0]     winner_o
  );

  always_comb begin
    logic        found;
    int unsigned idx;
    grant_o  = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = (int'(rr_ptr_i) + k) % num_req_p;
      if (!found && req_v_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = idx_w'(idx);
      end
    end
  end

endmodule

// File: rtl/bp_cce_hybrid_pending_w_arb.sv
// Round-robin arbiter sharing the pending-bit write port, with a one-entry output register.
// Optional starvation override: define BP_CCE_PENDING_W_ARB_STARVE_EN.
module bp_cce_hybrid_pending_w_arb
  import bp_me_pkg::*;
  #(parameter bp_params_e  bp_params_p    = e_bp_default_cfg
   ,parameter int unsigned num_req_p      = 3
   ,parameter int unsigned starve_limit_p = 16
   ,localparam int unsigned paddr_width_p = bp_paddr_width(bp_params_p)
   ,localparam int unsigned idx_w         = $clog2(num_req_p))
  (input  logic                               clk_i
  ,input  logic                               reset_i
  ,input  logic [num_req_p-1:0]               req_v_i
  ,output logic [num_req_p-1:0]               req_yumi_o
  ,input  logic [num_req_p*paddr_width_p-1:0] req_addr_i
  ,input  logic [num_req_p-1:0]               req_bypass_hash_i
  ,input  logic [num_req_p*2-1:0]             req_op_i
  ,output logic                               pending_w_v_o
  ,input  logic                               pending_w_yumi_i
  ,output logic [paddr_width_p-1:0]           pending_w_addr_o
  ,output logic                               pending_w_addr_bypass_hash_o
  ,output logic                               pending_up_o
  ,output logic                               pending_down_o
  ,output logic                               pending_clear_o
  ,output logic                               busy_o
  );

  bp_cce_pending_w_s        req_s [num_req_p];
  bp_cce_pending_w_s        out_r;
  logic                     busy_r;
  logic [idx_w-1:0]         rr_ptr_r;
  logic [num_req_p-1:0]     rr_grant, pick_grant;
  logic [idx_w-1:0]         rr_winner, winner;
  logic                     cap, grant_v;

  always_comb begin
    for (int unsigned i = 0; i < num_req_p; i++) begin
      req_s[i] = '{addr:        req_addr_i[i*paddr_width_p +: paddr_width_p],
                   bypass_hash: req_bypass_hash_i[i],
                   op:          bp_cce_pending_op_e'(req_op_i[2*i +: 2])};
    end
  end

  bp_cce_hybrid_pending_rr_pick #(.num_req_p(num_req_p)) rr_pick
    (.req_v_i (req_v_i)
    ,.rr_ptr_i(rr_ptr_r)
    ,.grant_o (rr_grant)
    ,.winner_o(rr_winner)
    );

  // Capture is allowed into an empty register or one draining this cycle.
  assign cap     = ~busy_r | pending_w_yumi_i;
  assign grant_v = cap & (|req_v_i) & ~reset_i;

`ifdef BP_CCE_PENDING_W_ARB_STARVE_EN
  localparam int unsigned cnt_w = $clog2(starve_limit_p + 1);

  logic [cnt_w-1:0]     wait_cnt_r [num_req_p];
  logic [num_req_p-1:0] starved;
  logic [idx_w-1:0]     starve_idx;

  always_comb begin
    starved    = '0;
    starve_idx = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      starved[i] = req_v_i[i] && (wait_cnt_r[i] == cnt_w'(starve_limit_p));
    end
    for (int unsigned i = num_req_p; i > 0; i--) begin
      if (starved[i-1]) starve_idx = idx_w'(i - 1);
    end
  end

  assign winner     = (|starved) ? starve_idx : rr_winner;
  assign pick_grant = (|starved) ? (num_req_p'(1) << starve_idx) : rr_grant;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < num_req_p; i++) wait_cnt_r[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        if (!req_v_i[i] || req_yumi_o[i])
          wait_cnt_r[i] <= '0;
        else if (wait_cnt_r[i] != cnt_w'(starve_limit_p))
          wait_cnt_r[i] <= wait_cnt_r[i] + 1'b1;
      end
    end
  end
`else
  assign winner     = rr_winner;
  assign pick_grant = rr_grant;
`endif

  assign req_yumi_o = grant_v ? pick_grant : '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_r   <= 1'b0;
      out_r    <= '0;
      rr_ptr_r <= '0;
    end else begin
      if (cap) begin
        busy_r <= grant_v;
        if (grant_v) out_r <= req_s[winner];
      end
      if (grant_v)
        rr_ptr_r <= (winner == idx_w'(num_req_p - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign pending_w_v_o                = busy_r;
  assign busy_o                       = busy_r;
  assign pending_w_addr_o             = out_r.addr;
  assign pending_w_addr_bypass_hash_o = out_r.bypass_hash;
  assign pending_up_o                 = busy_r && (out_r.op == e_pend_up);
  assign pending_down_o               = busy_r && (out_r.op == e_pend_down);
  assign pending_clear_o              = busy_r && (out_r.op == e_pend_clear);

  a_cfg: assert property (@(posedge clk_i) (num_req_p >= 2) && (starve_limit_p >= 1));
  a_yumi_without_v: assert property (@(posedge clk_i) disable iff (reset_i)
    pending_w_yumi_i |-> busy_r);
  a_illegal_op: assert property (@(posedge clk_i) disable iff (reset_i)
    grant_v |-> (2'(req_s[winner].op) != 2'b11));

endmodule

// File: tb/tb_bp_cce_hybrid_pending_w_arb.sv
// Directed bench for bp_cce_hybrid_pending_w_arb with a cycle-level reference model.
module tb_bp_cce_hybrid_pending_w_arb;
  import bp_me_pkg::*;

  localparam int unsigned N     = 3;
  localparam int unsigned AW    = 40;
  localparam int unsigned LIMIT = 4;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic [N-1:0]    req_v_i = '0;
  logic [N-1:0]    req_yumi_o;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N-1:0]    req_bypass_hash_i = '0;
  logic [N*2-1:0]  req_op_i = '0;
  logic            pending_w_v_o;
  logic            pending_w_yumi_i = 1'b0;
  logic [AW-1:0]   pending_w_addr_o;
  logic            pending_w_addr_bypass_hash_o;
  logic            pending_up_o, pending_down_o, pending_clear_o, busy_o;

  always #5 clk_i = ~clk_i;

  bp_cce_hybrid_pending_w_arb #(.num_req_p(N), .starve_limit_p(LIMIT)) dut
    (.clk_i(clk_i), .reset_i(reset_i)
    ,.req_v_i(req_v_i), .req_yumi_o(req_yumi_o)
    ,.req_addr_i(req_addr_i), .req_bypass_hash_i(req_bypass_hash_i), .req_op_i(req_op_i)
    ,.pending_w_v_o(pending_w_v_o), .pending_w_yumi_i(pending_w_yumi_i)
    ,.pending_w_addr_o(pending_w_addr_o)
    ,.pending_w_addr_bypass_hash_o(pending_w_addr_bypass_hash_o)
    ,.pending_up_o(pending_up_o), .pending_down_o(pending_down_o)
    ,.pending_clear_o(pending_clear_o), .busy_o(busy_o)
    );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one held write, a rotating priority start, per-requester wait ages.
  bit            m_busy;
  int unsigned   m_ptr;
  logic [AW-1:0] m_addr;
  logic          m_byp;
  logic [1:0]    m_op;
  int unsigned   m_wait [N];

  function automatic int model_winner();
    if (m_busy && !pending_w_yumi_i) return -1;
`ifdef BP_CCE_PENDING_W_ARB_STARVE_EN
    for (int unsigned i = 0; i < N; i++)
      if (req_v_i[i] && m_wait[i] >= LIMIT) return int'(i);
`endif
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned j;
      j = (m_ptr + k) % N;
      if (req_v_i[j]) return int'(j);
    end
    return -1;
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_busy <= 1'b0;
      m_ptr  <= 0;
      for (int unsigned i = 0; i < N; i++) m_wait[i] <= 0;
    end else begin
      int w;
      w = model_winner();
      for (int unsigned i = 0; i < N; i++)
        m_wait[i] <= (req_v_i[i] && w != int'(i)) ?
                     ((m_wait[i] + 1 > LIMIT) ? LIMIT : m_wait[i] + 1) : 0;
      if (!m_busy || pending_w_yumi_i) begin
        m_busy <= (w >= 0);
        if (w >= 0) begin
          m_addr <= req_addr_i[w*AW +: AW];
          m_byp  <= req_bypass_hash_i[w];
          m_op   <= req_op_i[w*2 +: 2];
          m_ptr  <= (w + 1) % N;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (!reset_i) begin
      int          w;
      logic [N-1:0] exp_yumi;
      w        = model_winner();
      exp_yumi = '0;
      if (w >= 0) exp_yumi[w] = 1'b1;
      check("yumi", req_yumi_o, exp_yumi);
      check("w_v", pending_w_v_o, m_busy);
      check("busy", busy_o, m_busy);
      if (m_busy) begin
        check("addr", pending_w_addr_o, m_addr);
        check("bypass", pending_w_addr_bypass_hash_o, m_byp);
      end
      check("up", pending_up_o, m_busy && m_op == 2'b00);
      check("down", pending_down_o, m_busy && m_op == 2'b01);
      check("clear", pending_clear_o, m_busy && m_op == 2'b10);
    end
  end

  task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic b,
                         input logic [1:0] op);
    req_addr_i[i*AW +: AW] = a;
    req_bypass_hash_i[i]   = b;
    req_op_i[i*2 +: 2]     = op;
  endtask

  task automatic apply(input logic [N-1:0] v, input bit r);
    req_v_i          = v;
    ready            = r;
    pending_w_yumi_i = r & m_busy;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #2;
    reset_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned order [$];
    int unsigned exp_order [6];
    exp_order = '{0, 1, 2, 0, 1, 2};
    for (int unsigned i = 0; i < N; i++)
      set_req(i, 40'h10_0000_0000 + AW'(i * 64), logic'(i == 2), 2'(i));

    tick();
    check("reset_v", pending_w_v_o, 1'b0);
    check("reset_yumi", req_yumi_o, 3'b000);
    reset_i = 1'b0;

    // Single requester
    set_req(1, 40'h00_8000_0040, 1'b0, e_pend_up);
    apply(3'b010, 1'b1);
    #2 check("s1_yumi", req_yumi_o, 3'b010);
    tick();
    apply(3'b000, 1'b1);
    #2;
    check("s1_v", pending_w_v_o, 1'b1);
    check("s1_addr", pending_w_addr_o, 40'h00_8000_0040);
    check("s1_up", pending_up_o, 1'b1);
    tick();
    apply(3'b000, 1'b0);
    tick();

    // Round-robin fairness from a fresh pointer
    do_reset();
    for (int unsigned c = 0; c < 6; c++) begin
      apply(3'b111, 1'b1);
      #2;
      for (int unsigned i = 0; i < N; i++) if (req_yumi_o[i]) order.push_back(i);
      tick();
    end
    check("rr_count", order.size(), 6);
    for (int unsigned c = 0; c < 6 && c < order.size(); c++)
      check("rr_order", order[c], exp_order[c]);
    apply(3'b000, 1'b1);
    tick();
    apply(3'b000, 1'b0);
    tick();

    // Backpressure, then flow-through on the draining cycle
    apply(3'b010, 1'b1);
    tick();
    for (int unsigned c = 0; c < 4; c++) begin
      apply(3'b001, 1'b0);
      #2;
      check("bp_yumi", req_yumi_o, 3'b000);
      check("bp_addr", pending_w_addr_o, 40'h00_8000_0040);
      check("bp_v", pending_w_v_o, 1'b1);
      tick();
    end
    apply(3'b001, 1'b1);
    #2 check("bp_flow", req_yumi_o, 3'b001);
    tick();
    apply(3'b000, 1'b1);
    tick();
    apply(3'b000, 1'b0);
    tick();

    // Op decode: down from requester 0, clear from requester 1
    do_reset();
    set_req(0, 40'h1000, 1'b0, e_pend_down);
    set_req(1, 40'h1000, 1'b1, e_pend_clear);
    apply(3'b011, 1'b1);
    tick();
    apply(3'b010, 1'b1);
    #2;
    check("op_down", {pending_up_o, pending_down_o, pending_clear_o}, 3'b010);
    tick();
    apply(3'b000, 1'b1);
    #2;
    check("op_clear", {pending_up_o, pending_down_o, pending_clear_o}, 3'b001);
    check("op_addr", pending_w_addr_o, 40'h1000);
    tick();
    apply(3'b000, 1'b0);
    tick();

    // Asynchronous reset while a write is held
    apply(3'b010, 1'b1);
    tick();
    apply(3'b000, 1'b0);
    #2 reset_i = 1'b1;
    #1;
    check("ar_v", pending_w_v_o, 1'b0);
    check("ar_up", pending_up_o, 1'b0);
    #3 reset_i = 1'b0;
    apply(3'b101, 1'b1);
    #1 check("ar_first", req_yumi_o, 3'b001);
    tick();
    apply(3'b000, 1'b1);
    tick();
    apply(3'b000, 1'b0);
    tick();

    // Requester 2 ages behind a stalled write, then competes with 0 and 1
    do_reset();
    apply(3'b011, 1'b1);
    tick();
    for (int unsigned c = 0; c < 5; c++) begin
      apply(3'b100, 1'b0);
      tick();
    end
    apply(3'b111, 1'b1);
    #2;
`ifdef BP_CCE_PENDING_W_ARB_STARVE_EN
    check("starve_pick", req_yumi_o, 3'b100);
`else
    check("starve_rr", req_yumi_o, 3'b010);
`endif
    tick();
    for (int unsigned c = 0; c < 3; c++) begin
      apply(3'b111, 1'b1);
      tick();
    end
    apply(3'b000, 1'b1);
    tick();
    apply(3'b000, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
